// File: rtl/rob_nway.sv
// rob_nway: parametrised N-wide reorder buffer. It accepts dispatch on a per-lane basis,
// retires in order up to RT_WIDTH entries per cycle, and squashes the whole buffer after
// a mispredicted branch retires.
module rob_nway #(
    parameter int unsigned ROB_SIZE  = 64,
    parameter int unsigned DP_WIDTH  = 2,
    parameter int unsigned RT_WIDTH  = 2,
    parameter int unsigned CMP_PORTS = 2,
    parameter int unsigned XLEN      = 32,
    parameter int unsigned PREG_W    = 6,
    parameter int unsigned IDX_W     = $clog2(ROB_SIZE)
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          dp_stall,
    input  logic [DP_WIDTH-1:0]           dp_valid,
    input  logic [DP_WIDTH*XLEN-1:0]      dp_pc,
    input  logic [DP_WIDTH*PREG_W-1:0]    dp_t_new,
    input  logic [DP_WIDTH*PREG_W-1:0]    dp_t_old,
    input  logic [DP_WIDTH-1:0]           dp_is_branch,
    output logic [DP_WIDTH-1:0]           dp_accept,
    output logic [DP_WIDTH*IDX_W-1:0]     dp_rob_idx,
    output logic [IDX_W:0]                dp_free_slots,
    input  logic [CMP_PORTS-1:0]          cmp_valid,
    input  logic [CMP_PORTS*IDX_W-1:0]    cmp_rob_idx,
    input  logic [CMP_PORTS-1:0]          cmp_mispredict,
    input  logic [CMP_PORTS*XLEN-1:0]     cmp_target_pc,
    output logic [RT_WIDTH-1:0]           rt_valid,
    output logic [RT_WIDTH*XLEN-1:0]      rt_pc,
    output logic [RT_WIDTH*PREG_W-1:0]    rt_t_new,
    output logic [RT_WIDTH*PREG_W-1:0]    rt_t_old,
    output logic                          flush,
    output logic [XLEN-1:0]               flush_pc,
    output logic [IDX_W-1:0]              head,
    output logic [IDX_W-1:0]              tail,
    output logic [IDX_W:0]                count
);

    localparam int unsigned CNT_W = IDX_W + 1;

    logic [ROB_SIZE-1:0] valid_q, valid_d;
    logic [ROB_SIZE-1:0] complete_q, complete_d;
    logic [ROB_SIZE-1:0] mispredict_q, mispredict_d;
    logic [ROB_SIZE-1:0] is_branch_q, is_branch_d;
    logic [XLEN-1:0]     pc_q [ROB_SIZE];
    logic [XLEN-1:0]     pc_d [ROB_SIZE];
    logic [XLEN-1:0]     target_pc_q [ROB_SIZE];
    logic [XLEN-1:0]     target_pc_d [ROB_SIZE];
    logic [PREG_W-1:0]   t_new_q [ROB_SIZE];
    logic [PREG_W-1:0]   t_new_d [ROB_SIZE];
    logic [PREG_W-1:0]   t_old_q [ROB_SIZE];
    logic [PREG_W-1:0]   t_old_d [ROB_SIZE];
    logic [IDX_W-1:0]    head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [CNT_W-1:0]    n_acc, n_ret;
    logic                ret_stop, dp_run;
    logic [IDX_W-1:0]    ret_idx, wr_idx, cmp_idx;

    // The branch flag is kept with each entry for debug visibility; nothing reads it yet.
    logic unused_is_branch;
    assign unused_is_branch = ^is_branch_q;

    assign head          = head_q;
    assign tail          = tail_q;
    assign count         = count_q;
    assign dp_free_slots = CNT_W'(ROB_SIZE) - count_q;

    // Retire: longest valid+complete prefix from head; stop after the first mispredicted entry.
    always_comb begin
        rt_valid = '0;
        rt_pc    = '0;
        rt_t_new = '0;
        rt_t_old = '0;
        flush    = 1'b0;
        flush_pc = '0;
        n_ret    = '0;
        ret_stop = 1'b0;
        ret_idx  = head_q;
        for (int j = 0; j < RT_WIDTH; j++) begin
            ret_idx = head_q + IDX_W'(j);
            rt_pc[j*XLEN +: XLEN]      = pc_q[ret_idx];
            rt_t_new[j*PREG_W +: PREG_W] = t_new_q[ret_idx];
            rt_t_old[j*PREG_W +: PREG_W] = t_old_q[ret_idx];
            if (!ret_stop && (CNT_W'(j) < count_q) && valid_q[ret_idx] && complete_q[ret_idx]) begin
                rt_valid[j] = 1'b1;
                n_ret       = CNT_W'(j + 1);
                if (mispredict_q[ret_idx]) begin
                    flush    = 1'b1;
                    flush_pc = target_pc_q[ret_idx];
                    ret_stop = 1'b1;
                end
            end else begin
                ret_stop = 1'b1;
            end
        end
    end

    // Dispatch acceptance: packed lane prefix limited by free slots counted at the start of the cycle.
    always_comb begin
        dp_accept  = '0;
        dp_rob_idx = '0;
        n_acc      = '0;
        dp_run     = reset_n && !dp_stall && !flush;
        for (int i = 0; i < DP_WIDTH; i++) begin
            dp_rob_idx[i*IDX_W +: IDX_W] = tail_q + IDX_W'(i);
            dp_run       = dp_run && dp_valid[i] && (dp_free_slots >= CNT_W'(i + 1));
            dp_accept[i] = dp_run;
            if (dp_run) begin
                n_acc = CNT_W'(i + 1);
            end
        end
    end

    // Next state: retire, allocate and complete entries; a flush overrides with a full squash.
    always_comb begin
        valid_d      = valid_q;
        complete_d   = complete_q;
        mispredict_d = mispredict_q;
        is_branch_d  = is_branch_q;
        pc_d         = pc_q;
        target_pc_d  = target_pc_q;
        t_new_d      = t_new_q;
        t_old_d      = t_old_q;
        head_d       = head_q + IDX_W'(n_ret);
        tail_d       = tail_q + IDX_W'(n_acc);
        count_d      = count_q + n_acc - n_ret;
        wr_idx       = tail_q;
        cmp_idx      = '0;

        for (int j = 0; j < RT_WIDTH; j++) begin
            if (rt_valid[j]) begin
                valid_d[head_q + IDX_W'(j)] = 1'b0;
            end
        end

        for (int i = 0; i < DP_WIDTH; i++) begin
            wr_idx = tail_q + IDX_W'(i);
            if (dp_accept[i]) begin
                valid_d[wr_idx]      = 1'b1;
                complete_d[wr_idx]   = 1'b0;
                mispredict_d[wr_idx] = 1'b0;
                is_branch_d[wr_idx]  = dp_is_branch[i];
                pc_d[wr_idx]         = dp_pc[i*XLEN +: XLEN];
                t_new_d[wr_idx]      = dp_t_new[i*PREG_W +: PREG_W];
                t_old_d[wr_idx]      = dp_t_old[i*PREG_W +: PREG_W];
            end
        end

        for (int k = 0; k < CMP_PORTS; k++) begin
            cmp_idx = cmp_rob_idx[k*IDX_W +: IDX_W];
            if (!flush && cmp_valid[k] && valid_q[cmp_idx]) begin
                complete_d[cmp_idx] = 1'b1;
                if (cmp_mispredict[k]) begin
                    mispredict_d[cmp_idx] = 1'b1;
                    target_pc_d[cmp_idx]  = cmp_target_pc[k*XLEN +: XLEN];
                end
            end
        end

        if (flush) begin
            valid_d = '0;
            tail_d  = head_d;
            count_d = '0;
        end
    end

    // State registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            valid_q      <= '0;
            complete_q   <= '0;
            mispredict_q <= '0;
            is_branch_q  <= '0;
            for (int e = 0; e < ROB_SIZE; e++) begin
                pc_q[e]        <= '0;
                target_pc_q[e] <= '0;
                t_new_q[e]     <= '0;
                t_old_q[e]     <= '0;
            end
        end else begin
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            valid_q      <= valid_d;
            complete_q   <= complete_d;
            mispredict_q <= mispredict_d;
            is_branch_q  <= is_branch_d;
            pc_q         <= pc_d;
            target_pc_q  <= target_pc_d;
            t_new_q      <= t_new_d;
            t_old_q      <= t_old_d;
        end
    end

endmodule

// File: tb/tb_rob_nway.sv
// tb_rob_nway: directed scoreboard bench for rob_nway with an 8-entry, 2-wide configuration.
module tb_rob_nway;

    localparam int unsigned RS = 8;
    localparam int unsigned DW = 2;
    localparam int unsigned RW = 2;
    localparam int unsigned CP = 2;
    localparam int unsigned XL = 32;
    localparam int unsigned PW = 6;
    localparam int unsigned IW = 3;

    logic              clock = 1'b0;
    logic              reset_n;
    logic              dp_stall;
    logic [DW-1:0]     dp_valid;
    logic [DW*XL-1:0]  dp_pc;
    logic [DW*PW-1:0]  dp_t_new, dp_t_old;
    logic [DW-1:0]     dp_is_branch;
    logic [DW-1:0]     dp_accept;
    logic [DW*IW-1:0]  dp_rob_idx;
    logic [IW:0]       dp_free_slots;
    logic [CP-1:0]     cmp_valid;
    logic [CP*IW-1:0]  cmp_rob_idx;
    logic [CP-1:0]     cmp_mispredict;
    logic [CP*XL-1:0]  cmp_target_pc;
    logic [RW-1:0]     rt_valid;
    logic [RW*XL-1:0]  rt_pc;
    logic [RW*PW-1:0]  rt_t_new, rt_t_old;
    logic              flush;
    logic [XL-1:0]     flush_pc;
    logic [IW-1:0]     head, tail;
    logic [IW:0]       count;

    rob_nway #(.ROB_SIZE(RS), .DP_WIDTH(DW), .RT_WIDTH(RW), .CMP_PORTS(CP),
               .XLEN(XL), .PREG_W(PW)) dut (
        .clock(clock), .reset_n(reset_n), .dp_stall(dp_stall), .dp_valid(dp_valid),
        .dp_pc(dp_pc), .dp_t_new(dp_t_new), .dp_t_old(dp_t_old), .dp_is_branch(dp_is_branch),
        .dp_accept(dp_accept), .dp_rob_idx(dp_rob_idx), .dp_free_slots(dp_free_slots),
        .cmp_valid(cmp_valid), .cmp_rob_idx(cmp_rob_idx), .cmp_mispredict(cmp_mispredict),
        .cmp_target_pc(cmp_target_pc), .rt_valid(rt_valid), .rt_pc(rt_pc),
        .rt_t_new(rt_t_new), .rt_t_old(rt_t_old), .flush(flush), .flush_pc(flush_pc),
        .head(head), .tail(tail), .count(count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] pc;
        logic [5:0]  tn;
        logic [5:0]  to;
        logic        fl;
        logic [31:0] fpc;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] sh_pc [RS];
    logic [5:0]  sh_tn [RS];
    logic [5:0]  sh_to [RS];
    logic [2:0]  m_tail;
    int          seq;
    int          n_chk;
    int          n_pass;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_ret(input int idx, input logic fl, input logic [31:0] fpc);
        exp_t e;
        e.pc  = sh_pc[idx];
        e.tn  = sh_tn[idx];
        e.to  = sh_to[idx];
        e.fl  = fl;
        e.fpc = fpc;
        sbq.push_back(e);
    endtask

    // Drive n packed lanes for one cycle, check acceptance and assigned indices.
    task automatic dispatch(input int n, input logic [1:0] br, input logic stall,
                            input logic [1:0] exp_acc);
        int         acc;
        logic [2:0] idx;
        dp_stall = stall;
        for (int i = 0; i < DW; i++) begin
            dp_valid[i]           = (i < n);
            dp_pc[i*XL +: XL]     = 32'h1000 + 32'((seq + i) * 4);
            dp_t_new[i*PW +: PW]  = 6'(seq + i);
            dp_t_old[i*PW +: PW]  = 6'(seq + i + 40);
            dp_is_branch[i]       = br[i];
        end
        @(negedge clock);
        chk("dp_accept", 64'(dp_accept), 64'(exp_acc));
        acc = 0;
        for (int i = 0; i < DW; i++) begin
            if (exp_acc[i]) begin
                idx = m_tail + 3'(i);
                chk("dp_rob_idx", 64'(dp_rob_idx[i*IW +: IW]), 64'(idx));
                sh_pc[idx] = 32'h1000 + 32'((seq + i) * 4);
                sh_tn[idx] = 6'(seq + i);
                sh_to[idx] = 6'(seq + i + 40);
                acc++;
            end
        end
        step();
        m_tail       = m_tail + 3'(acc);
        seq          = seq + acc;
        dp_valid     = '0;
        dp_stall     = 1'b0;
        dp_is_branch = '0;
    endtask

    task automatic cmp(input logic [1:0] v, input int i0, input int i1, input logic [1:0] mp,
                       input logic [31:0] t0, input logic [31:0] t1);
        cmp_valid      = v;
        cmp_rob_idx    = {3'(i1), 3'(i0)};
        cmp_mispredict = mp;
        cmp_target_pc  = {t1, t0};
        step();
        cmp_valid      = '0;
        cmp_mispredict = '0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        step();
        m_tail = '0;
    endtask

    task automatic chk_ptr(input logic [2:0] h, input logic [2:0] t, input logic [3:0] c);
        chk("head", 64'(head), 64'(h));
        chk("tail", 64'(tail), 64'(t));
        chk("count", 64'(count), 64'(c));
    endtask

    // Scoreboard monitor: every retiring lane must match the next expected retirement.
    always @(negedge clock) begin
        if (reset_n === 1'b1) begin
            logic        any;
            logic        efl;
            logic [31:0] efpc;
            exp_t        e;
            any  = 1'b0;
            efl  = 1'b0;
            efpc = '0;
            for (int j = 0; j < RW; j++) begin
                if (rt_valid[j]) begin
                    any = 1'b1;
                    if (sbq.size() == 0) begin
                        n_chk++;
                        $display("FAIL unexpected_retire: lane %0d pc %0h, nothing expected", j,
                                 rt_pc[j*XL +: XL]);
                    end else begin
                        e = sbq.pop_front();
                        chk("rt_pc", 64'(rt_pc[j*XL +: XL]), 64'(e.pc));
                        chk("rt_t_new", 64'(rt_t_new[j*PW +: PW]), 64'(e.tn));
                        chk("rt_t_old", 64'(rt_t_old[j*PW +: PW]), 64'(e.to));
                        if (e.fl) begin
                            efl  = 1'b1;
                            efpc = e.fpc;
                        end
                    end
                end
            end
            if (any) begin
                chk("flush", 64'(flush), 64'(efl));
                chk("flush_pc", 64'(flush_pc), 64'(efpc));
            end
        end
    end

    // Stimulus protocol assertions.
    always @(negedge clock) begin
        if (reset_n === 1'b1) begin
            assert (dp_valid != 2'b10) else $error("non-packed dp_valid driven");
            assert (!(cmp_valid == 2'b11 && cmp_rob_idx[2:0] == cmp_rob_idx[5:3]))
                else $error("two completions to one index");
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk = 0; n_pass = 0; seq = 0; m_tail = '0;
        reset_n = 1'b0; dp_stall = 1'b0; dp_valid = 2'b11; dp_pc = '0;
        dp_t_new = '0; dp_t_old = '0; dp_is_branch = '0;
        cmp_valid = '0; cmp_rob_idx = '0; cmp_mispredict = '0; cmp_target_pc = '0;

        // Reset values while in reset (requested lanes must still not be accepted).
        #3;
        chk_ptr(3'd0, 3'd0, 4'd0);
        chk("rst_free", 64'(dp_free_slots), 64'd8);
        chk("rst_rt_valid", 64'(rt_valid), 64'd0);
        chk("rst_flush", 64'(flush), 64'd0);
        chk("rst_dp_accept", 64'(dp_accept), 64'd0);
        dp_valid = '0;
        @(negedge clock);
        reset_n = 1'b1;
        step();

        // 1: fill, then a same-cycle retire does not free space until the next cycle.
        for (int c = 0; c < 4; c++) dispatch(2, 2'b00, 1'b0, 2'b11);
        chk_ptr(3'd0, 3'd0, 4'd8);
        chk("full_free", 64'(dp_free_slots), 64'd0);
        expect_ret(0, 1'b0, 32'h0);
        cmp(2'b01, 0, 0, 2'b00, 32'h0, 32'h0);
        chk("t1_rt_valid", 64'(rt_valid), 64'b01);
        dispatch(2, 2'b00, 1'b0, 2'b00);
        chk_ptr(3'd1, 3'd0, 4'd7);
        chk("t1_free", 64'(dp_free_slots), 64'd1);
        dispatch(2, 2'b00, 1'b0, 2'b01);
        chk_ptr(3'd1, 3'd1, 4'd8);

        // 2: out-of-order completion, in-order retire with a gap.
        do_reset();
        dispatch(2, 2'b00, 1'b1, 2'b00);
        dispatch(2, 2'b00, 1'b0, 2'b11);
        dispatch(2, 2'b00, 1'b0, 2'b11);
        cmp(2'b11, 2, 3, 2'b00, 32'h0, 32'h0);
        chk("t2_gap", 64'(rt_valid), 64'b00);
        expect_ret(0, 1'b0, 32'h0);
        cmp(2'b01, 0, 0, 2'b00, 32'h0, 32'h0);
        chk("t2_one", 64'(rt_valid), 64'b01);
        expect_ret(1, 1'b0, 32'h0);
        expect_ret(2, 1'b0, 32'h0);
        expect_ret(3, 1'b0, 32'h0);
        cmp(2'b01, 1, 0, 2'b00, 32'h0, 32'h0);
        chk("t2_two", 64'(rt_valid), 64'b11);
        step();
        chk("t2_last", 64'(rt_valid), 64'b01);
        step();
        chk_ptr(3'd4, 3'd4, 4'd0);

        // 3: mispredicted branch in lane 1 retires with lane 0, then squash.
        do_reset();
        dispatch(2, 2'b10, 1'b0, 2'b11);
        dispatch(2, 2'b00, 1'b0, 2'b11);
        cmp(2'b11, 2, 3, 2'b00, 32'h0, 32'h0);
        chk("t3_wait", 64'(rt_valid), 64'b00);
        expect_ret(0, 1'b0, 32'h0);
        expect_ret(1, 1'b1, 32'h100);
        cmp(2'b11, 0, 1, 2'b10, 32'h0, 32'h100);
        chk("t3_rt_valid", 64'(rt_valid), 64'b11);
        chk("t3_flush", 64'(flush), 64'd1);
        chk("t3_flush_pc", 64'(flush_pc), 64'h100);
        dispatch(2, 2'b00, 1'b0, 2'b00);
        chk_ptr(3'd2, 3'd2, 4'd0);
        chk("t3_flush_off", 64'(flush_pc), 64'd0);
        m_tail = 3'd2;
        step();
        chk("t3_no_retire", 64'(rt_valid), 64'b00);

        // 4: advance to 6, then wrap through the end of the buffer.
        dispatch(2, 2'b00, 1'b0, 2'b11);
        dispatch(2, 2'b00, 1'b0, 2'b11);
        for (int i = 2; i < 6; i++) expect_ret(i, 1'b0, 32'h0);
        cmp(2'b11, 2, 3, 2'b00, 32'h0, 32'h0);
        cmp(2'b11, 4, 5, 2'b00, 32'h0, 32'h0);
        step();
        chk_ptr(3'd6, 3'd6, 4'd0);
        dispatch(2, 2'b00, 1'b0, 2'b11);
        dispatch(2, 2'b00, 1'b0, 2'b11);
        expect_ret(6, 1'b0, 32'h0);
        expect_ret(7, 1'b0, 32'h0);
        expect_ret(0, 1'b0, 32'h0);
        expect_ret(1, 1'b0, 32'h0);
        cmp(2'b11, 6, 7, 2'b00, 32'h0, 32'h0);
        chk("t4_rt_a", 64'(rt_valid), 64'b11);
        cmp(2'b11, 0, 1, 2'b00, 32'h0, 32'h0);
        chk("t4_rt_b", 64'(rt_valid), 64'b11);
        step();
        chk_ptr(3'd2, 3'd2, 4'd0);

        // 5: asynchronous reset mid-cycle with five entries occupied.
        dispatch(2, 2'b00, 1'b0, 2'b11);
        dispatch(2, 2'b00, 1'b0, 2'b11);
        dispatch(1, 2'b00, 1'b0, 2'b01);
        chk("t5_count", 64'(count), 64'd5);
        #2;
        reset_n = 1'b0;
        #1;
        chk_ptr(3'd0, 3'd0, 4'd0);
        chk("t5_rt_valid", 64'(rt_valid), 64'd0);
        chk("t5_free", 64'(dp_free_slots), 64'd8);
        @(posedge clock);
        #3;
        reset_n = 1'b1;
        step();
        m_tail = '0;
        dispatch(1, 2'b00, 1'b0, 2'b01);
        chk_ptr(3'd0, 3'd1, 4'd1);

        // 6: lane-0 mispredict blocks a complete lane 1; late completion to squashed entry ignored.
        do_reset();
        dispatch(2, 2'b01, 1'b0, 2'b11);
        expect_ret(0, 1'b1, 32'h200);
        cmp(2'b11, 1, 0, 2'b10, 32'h0, 32'h200);
        chk("t6_rt_valid", 64'(rt_valid), 64'b01);
        chk("t6_flush", 64'(flush), 64'd1);
        chk("t6_flush_pc", 64'(flush_pc), 64'h200);
        step();
        chk_ptr(3'd1, 3'd1, 4'd0);
        cmp(2'b01, 1, 0, 2'b00, 32'h0, 32'h0);
        chk("t6_count", 64'(count), 64'd0);
        chk("t6_rt_none", 64'(rt_valid), 64'b00);
        step();
        chk_ptr(3'd1, 3'd1, 4'd0);
        chk("t6_rt_none2", 64'(rt_valid), 64'b00);

        chk("sb_drained", 64'(sbq.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
